// File: rtl/fp32_divider_if.sv
// Handshake and operand bundle shared by the FP32 divider and its requester.
interface fp32_divider_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        En;
    logic [31:0] Result;
    logic        Ready;
    logic        NaN;
    logic        DivZero;
    logic        Busy;

    modport master (
        output A, B, En,
        input  Result, Ready, NaN, DivZero, Busy
    );

    modport slave (
        input  A, B, En,
        output Result, Ready, NaN, DivZero, Busy
    );
endinterface

// File: rtl/fp32_divider.sv
// Multi-cycle IEEE-754 single-precision divider: Result = A / B.
// Restoring division (one quotient bit per cycle), round-to-nearest-even,
// denormal inputs and outputs flushed to zero.
module fp32_divider (
    input  logic          clk,
    input  logic          reset,
    fp32_divider_if.slave bus
);
    // Quotient bits generated: 24 mantissa bits plus one guard bit.
    localparam int unsigned ITER = 25;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PREP,
        DIVIDE,
        ROUND,
        FINAL
    } state_t;

    state_t             state;
    logic               sign;
    logic [7:0]         exp_a;
    logic [7:0]         exp_b;
    logic [23:0]        ma;
    logic [23:0]        mb;
    logic signed [9:0]  e;
    logic [25:0]        rem;
    logic [23:0]        q;
    logic [4:0]         count;
    logic [22:0]        mant;
    logic [31:0]        result;
    logic               ready;
    logic               nan;
    logic               div_zero;

    logic               a_zero;
    logic               a_inf;
    logic               a_nan;
    logic               b_zero;
    logic               b_inf;
    logic               b_nan;
    logic signed [9:0]  e_prep;
    logic               rem_ge;
    logic               round_up;
    logic [23:0]        frac_sum;

    // Operand classification, exponent estimate and rounding helpers.
    always_comb begin
        a_zero   = (exp_a == 8'h00);
        a_inf    = (exp_a == 8'hFF) && (ma[22:0] == '0);
        a_nan    = (exp_a == 8'hFF) && (ma[22:0] != '0);
        b_zero   = (exp_b == 8'h00);
        b_inf    = (exp_b == 8'hFF) && (mb[22:0] == '0);
        b_nan    = (exp_b == 8'hFF) && (mb[22:0] != '0);
        e_prep   = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
        rem_ge   = (rem >= {2'b00, mb});
        // The leading quotient bit is always 1 and has shifted out of q,
        // so q[23:1] is the stored fraction and q[0] the guard bit.
        round_up = q[0] & ((rem != '0) | q[1]);
        frac_sum = {1'b0, q[23:1]} + {23'b0, round_up};
    end

    assign bus.Result  = result;
    assign bus.Ready   = ready;
    assign bus.NaN     = nan;
    assign bus.DivZero = div_zero;
    assign bus.Busy    = (state != IDLE);

    // Control FSM and datapath with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sign     <= 1'b0;
            exp_a    <= '0;
            exp_b    <= '0;
            ma       <= '0;
            mb       <= '0;
            e        <= '0;
            rem      <= '0;
            q        <= '0;
            count    <= '0;
            mant     <= '0;
            result   <= '0;
            ready    <= 1'b0;
            nan      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.En) begin
                        sign     <= bus.A[31] ^ bus.B[31];
                        exp_a    <= bus.A[30:23];
                        exp_b    <= bus.B[30:23];
                        ma       <= {|bus.A[30:23], bus.A[22:0]};
                        mb       <= {|bus.B[30:23], bus.B[22:0]};
                        nan      <= 1'b0;
                        div_zero <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        result <= 32'h7FC0_0000;
                        nan    <= 1'b1;
                        ready  <= 1'b1;
                        state  <= IDLE;
                    end else if (a_inf) begin
                        result <= {sign, 8'hFF, 23'b0};
                        ready  <= 1'b1;
                        state  <= IDLE;
                    end else if (b_zero) begin
                        result   <= {sign, 8'hFF, 23'b0};
                        div_zero <= 1'b1;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else if (a_zero || b_inf) begin
                        result <= {sign, 31'b0};
                        ready  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (ma < mb) begin
                        rem <= {1'b0, ma, 1'b0};
                        e   <= e_prep - 10'sd1;
                    end else begin
                        rem <= {2'b00, ma};
                        e   <= e_prep;
                    end
                    count <= 5'(ITER - 1);
                    q     <= '0;
                    state <= DIVIDE;
                end
                DIVIDE: begin
                    q <= {q[22:0], rem_ge};
                    if (rem_ge) begin
                        rem <= (rem - {2'b00, mb}) << 1;
                    end else begin
                        rem <= rem << 1;
                    end
                    count <= count - 5'd1;
                    if (count == '0) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    mant <= frac_sum[22:0];
                    if (frac_sum[23]) begin
                        e <= e + 10'sd1;
                    end
                    state <= FINAL;
                end
                FINAL: begin
                    if (e >= 10'sd255) begin
                        result <= {sign, 8'hFF, 23'b0};
                    end else if (e <= 10'sd0) begin
                        result <= {sign, 31'b0};
                    end else begin
                        result <= {sign, e[7:0], mant};
                    end
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_divider.sv
// Self-checking bench for fp32_divider: vector table plus scoreboard,
// with hand-written sequences for back-to-back issue and mid-op reset.
module tb_fp32_divider;
    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;

    fp32_divider_if bus ();

    fp32_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nan;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        nan;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[22];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter; at a falling edge it equals the number of rising edges seen.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every Ready pulse pops one expected completion.
    always @(negedge clk) begin
        if (bus.Ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got Result %h at cycle %0d expected no completion", bus.Result, cyc);
            end else begin
                cur = sb.pop_front();
                check("result", bus.Result, cur.res);
                check("nan", 32'(bus.NaN), 32'(cur.nan));
                check("divzero", 32'(bus.DivZero), 32'(cur.dz));
                check("ready_cycle", 32'(cyc), 32'(cur.due));
            end
        end
    end

    task automatic push_exp(input logic [31:0] res, input logic n, input logic dz, input int lat);
        exp_t x;
        x.res = res;
        x.nan = n;
        x.dz  = dz;
        x.due = cyc + 1 + lat;
        sb.push_back(x);
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        check({name, "_busy_done"}, 32'(bus.Busy), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        bus.A  = v.a;
        bus.B  = v.b;
        bus.En = 1'b1;
        push_exp(v.res, v.nan, v.dz, v.lat);
        @(negedge clk);
        bus.En = 1'b0;
        bus.A  = $urandom;
        bus.B  = $urandom;
        check($sformatf("vec%0d_busy", idx), 32'(bus.Busy), 32'd1);
        wait_drained($sformatf("vec%0d", idx));
    endtask

    initial begin
        int n;
        int start;
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 29}; // 6/2
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 29}; // 1/3 rounds up
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 29}; // 1/1
        vecs[3]  = '{32'hC0000000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1, 1};  // -2/0
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 1};  // 0/0
        vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 1};  // inf/inf
        vecs[6]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, 29}; // overflow
        vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 29}; // underflow
        vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 1};  // NaN operand
        vecs[9]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0, 1};  // inf/2
        vecs[10] = '{32'hFF800000, 32'hC0000000, 32'h7F800000, 1'b0, 1'b0, 1};  // -inf/-2
        vecs[11] = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0, 1};  // -0/5
        vecs[12] = '{32'h40400000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1};  // 3/-inf
        vecs[13] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1};  // inf/0
        vecs[14] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 29}; // -6/2
        vecs[15] = '{32'h41200000, 32'h40800000, 32'h40200000, 1'b0, 1'b0, 29}; // 10/4
        vecs[16] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1};  // denormal / 1
        vecs[17] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, 29}; // E = 254
        vecs[18] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0, 29}; // E = 255
        vecs[19] = '{32'h01000000, 32'h40000000, 32'h00800000, 1'b0, 1'b0, 29}; // E = 1
        vecs[20] = '{32'h3F800000, 32'h3F7FFFFF, 32'h3F800001, 1'b0, 1'b0, 29}; // 1/(1-2^-24)
        vecs[21] = '{32'h40A00000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 1};  // 5/0

        cyc    = 0;
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        bus.En = 1'b0;
        bus.A  = '0;
        bus.B  = '0;
        repeat (3) @(negedge clk);
        check("reset_result", bus.Result, 32'd0);
        check("reset_ready", 32'(bus.Ready), 32'd0);
        check("reset_nan", 32'(bus.NaN), 32'd0);
        check("reset_divzero", 32'(bus.DivZero), 32'd0);
        check("reset_busy", 32'(bus.Busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            run_vec(i, vecs[i]);
        end

        // En held high with new operands while busy; second op taken at the Ready edge.
        @(negedge clk);
        bus.A  = 32'h40C00000;
        bus.B  = 32'h40000000;
        bus.En = 1'b1;
        push_exp(32'h40400000, 1'b0, 1'b0, 29);
        @(negedge clk);
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
        check("hold_busy", 32'(bus.Busy), 32'd1);
        n = 0;
        while (bus.Ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.Ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_first_ready_timeout: got no Ready expected Ready within 60 cycles");
        end else begin
            push_exp(32'h3EAAAAAB, 1'b0, 1'b0, 29);
        end
        @(negedge clk);
        bus.En = 1'b0;
        check("b2b_busy", 32'(bus.Busy), 32'd1);
        wait_drained("b2b");

        // Reset during the divide phase aborts the operation.
        @(negedge clk);
        bus.A  = 32'h40C00000;
        bus.B  = 32'h40000000;
        bus.En = 1'b1;
        start  = cyc + 1;
        push_exp(32'h40400000, 1'b0, 1'b0, 29);
        @(negedge clk);
        bus.En = 1'b0;
        while (cyc < start + 10) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        check("abort_result", bus.Result, 32'd0);
        check("abort_ready", 32'(bus.Ready), 32'd0);
        check("abort_nan", 32'(bus.NaN), 32'd0);
        check("abort_divzero", 32'(bus.DivZero), 32'd0);
        check("abort_busy", 32'(bus.Busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (35) @(negedge clk);
        check("abort_no_resume_result", bus.Result, 32'd0);
        check("abort_no_resume_busy", 32'(bus.Busy), 32'd0);
        run_vec(99, vecs[0]);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
